// File: rtl/cycle_checkpoint_monitor_if.sv
// cycle_checkpoint_monitor_if: config, core-control and register-file read signals of the checkpoint monitor.
interface cycle_checkpoint_monitor_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CYC_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W = 32
);
  localparam int FF_W = $clog2(NUM_CH) + 1;
  logic start;
  logic [PC_W-1:0] pc_start;
  logic [CYC_W-1:0] checkpoint;
  logic [NUM_CH*ADDR_W-1:0] chk_addr;
  logic [NUM_CH*DATA_W-1:0] chk_expect;
  logic [NUM_CH-1:0] chk_mask;
  logic cpu_halt;
  logic [DATA_W-1:0] rf_rd_data;
  logic pc_load;
  logic [PC_W-1:0] pc_init;
  logic cpu_run;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [CYC_W-1:0] cycle_count;
  logic busy;
  logic done;
  logic pass;
  logic [NUM_CH-1:0] fail_mask;
  logic [FF_W-1:0] first_fail;
  logic [DATA_W-1:0] first_data;
  logic early_halt;
  modport master (
    output start, pc_start, checkpoint, chk_addr, chk_expect, chk_mask, cpu_halt, rf_rd_data,
    input pc_load, pc_init, cpu_run, rf_rd_addr, cycle_count, busy, done, pass, fail_mask,
    first_fail, first_data, early_halt
  );
  modport slave (
    input start, pc_start, checkpoint, chk_addr, chk_expect, chk_mask, cpu_halt, rf_rd_data,
    output pc_load, pc_init, cpu_run, rf_rd_addr, cycle_count, busy, done, pass, fail_mask,
    first_fail, first_data, early_halt
  );
endinterface

// File: rtl/cycle_checkpoint_monitor.sv
// cycle_checkpoint_monitor: loads a start PC, runs the core for a cycle budget, then sweeps register checks.
module cycle_checkpoint_monitor #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CYC_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W = 32
) (
  input logic clk,
  input logic rst,
  cycle_checkpoint_monitor_if.slave bus
);
  localparam int FF_W = $clog2(NUM_CH) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CYC_W-1:0] cp_q, cp_d, cnt_q, cnt_d;
  logic [NUM_CH*ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0] exp_q, exp_d;
  logic [NUM_CH-1:0] mask_q, mask_d, fail_q, fail_d;
  logic [FF_W-1:0] idx_q, idx_d, ff_q, ff_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic early_q, early_d, done_q, done_d, pass_q, pass_d;
  logic reached, stop, last, miss, none_yet;
  assign reached = cnt_q >= cp_q;
  assign stop = reached || bus.cpu_halt;
  assign last = idx_q == FF_W'(NUM_CH - 1);
  assign none_yet = ff_q == FF_W'(NUM_CH);
  assign miss = state_q == CHECK && mask_q[idx_q] && bus.rf_rd_data != exp_q[idx_q*DATA_W +: DATA_W];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cp_d = cp_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    exp_d = exp_q;
    mask_d = mask_q;
    fail_d = fail_q;
    idx_d = idx_q;
    ff_d = ff_q;
    fd_d = fd_q;
    early_d = early_q;
    done_d = done_q;
    pass_d = pass_q;
    if (bus.start && (state_q == IDLE || state_q == DONE)) begin
      pc_d = bus.pc_start;
      cp_d = bus.checkpoint;
      addr_d = bus.chk_addr;
      exp_d = bus.chk_expect;
      mask_d = bus.chk_mask;
      fail_d = '0;
      idx_d = '0;
      ff_d = FF_W'(NUM_CH);
      fd_d = '0;
      early_d = 1'b0;
      done_d = 1'b0;
      pass_d = 1'b0;
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          cnt_d = CYC_W'(1);
          state_d = RUN;
        end
        RUN: begin
          state_d = stop ? CHECK : RUN;
          early_d = !reached && bus.cpu_halt;
          cnt_d = (stop || &cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
        CHECK: begin
          if (miss) fail_d[idx_q] = 1'b1;
          ff_d = (miss && none_yet) ? idx_q : ff_q;
          fd_d = (miss && none_yet) ? bus.rf_rd_data : fd_q;
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? DONE : CHECK;
          done_d = last;
          pass_d = last && fail_d == '0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      cp_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      exp_q <= '0;
      mask_q <= '0;
      fail_q <= '0;
      idx_q <= '0;
      ff_q <= FF_W'(NUM_CH);
      fd_q <= '0;
      early_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cp_q <= cp_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      exp_q <= exp_d;
      mask_q <= mask_d;
      fail_q <= fail_d;
      idx_q <= idx_d;
      ff_q <= ff_d;
      fd_q <= fd_d;
      early_q <= early_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  // run enable and read address are combinational so a halt or reset takes effect within the cycle
  assign bus.pc_load = state_q == LOAD;
  assign bus.pc_init = pc_q;
  assign bus.cpu_run = state_q == RUN && !stop;
  assign bus.rf_rd_addr = state_q == CHECK ? addr_q[idx_q*ADDR_W +: ADDR_W] : '0;
  assign bus.cycle_count = cnt_q;
  assign bus.busy = state_q == LOAD || state_q == RUN || state_q == CHECK;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.first_fail = ff_q;
  assign bus.first_data = fd_q;
  assign bus.early_halt = early_q;
endmodule
